imem_loader: RTL and testbench

//  Byte-stream program loader: the writer side of the imem Altair-mode write port.

---
 rtl/imem_loader_if.sv | 31 +++
 rtl/imem_loader.sv | 188 ++++++++++++++++++
 tb/tb_imem_loader.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_loader_if.sv
// Bundle of signals between a byte-stream host and the imem program loader.
// slave:  the loader side (consumes host bytes, drives the imem write port
//         and frame status).
// master: the host/observer side.
// ADDR_WIDTH must match the ADDR_WIDTH of the imem_loader it connects to.
interface imem_loader_if #(
  parameter int ADDR_WIDTH = 14
);
  logic                  in_valid;
  logic [7:0]            in_data;
  logic                  in_ready;
  logic                  altair_we;
  logic [ADDR_WIDTH-1:0] altair_waddr;
  logic [15:0]           altair_wdata;
  logic                  cpu_hold;
  logic                  load_done;
  logic                  load_err;
  logic [15:0]           words_loaded;

  modport slave (
    input  in_valid, in_data,
    output in_ready, altair_we, altair_waddr, altair_wdata,
           cpu_hold, load_done, load_err, words_loaded
  );

  modport master (
    output in_valid, in_data,
    input  in_ready, altair_we, altair_waddr, altair_wdata,
           cpu_hold, load_done, load_err, words_loaded
  );
endinterface

// File: rtl/imem_loader.sv
// imem_loader: byte-stream program loader driving the imem Altair-mode write port.
// Frame: SYNC, ADDR_LO, ADDR_HI, LEN_LO, LEN_HI, LEN x {DATA_LO, DATA_HI}, [CSUM].
// cpu_hold is raised when SYNC is accepted and dropped when the frame ends.
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN adds a trailing CSUM byte
// (8-bit sum of every byte after SYNC); a mismatch ends the frame with load_err.
// ADDR_WIDTH is limited to 16 (the frame carries a 16-bit address).
module imem_loader #(
  parameter int         ADDR_WIDTH     = 14,
  parameter logic [7:0] SYNC_BYTE      = 8'hA5,
  parameter int         TIMEOUT_CYCLES = 1000000
) (
  input  logic             clk,
  input  logic             rst_n,
  imem_loader_if.slave     bus
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_ADDR_LO,
    S_ADDR_HI,
    S_LEN_LO,
    S_LEN_HI,
    S_DATA_LO,
    S_DATA_HI,
`ifdef IMEM_LOADER_CHECKSUM_EN
    S_CSUM,
`endif
    S_DONE
  } state_t;

  // State entered once the last data word (or an empty LEN) has been accepted.
`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam state_t S_POST = S_CSUM;
`else
  localparam state_t S_POST = S_DONE;
`endif

  // Idle counter only needs to reach TIMEOUT_CYCLES-1.
  localparam int            TW     = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);

  state_t                state_q, state_d;
  logic                  xfer;
  logic [15:0]           hi_word;
  logic                  timeout_hit;
  logic                  fail_d;
  logic                  fail_q;
  logic [7:0]            byte_lo_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [15:0]           remaining_q;
  logic [TW-1:0]         tcount_q;
  logic                  in_ready_q;
  logic                  we_q;
  logic [ADDR_WIDTH-1:0] waddr_q;
  logic [15:0]           wdata_q;
  logic                  hold_q;
  logic                  done_q;
  logic                  err_q;
  logic [15:0]           words_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]            csum_q;
`endif

  assign xfer    = bus.in_valid & in_ready_q;
  // Upper byte just arriving joined with the low byte captured one transfer earlier.
  assign hi_word = {bus.in_data, byte_lo_q};

  // Timeout fires on the last permitted idle clock inside a frame.
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && !xfer &&
                       (state_q != S_IDLE) && (state_q != S_DONE) &&
                       (tcount_q == T_LAST);

  // Next-state decode and frame outcome for the DONE state.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned, which would infer a latch.
    state_d = state_q;
    fail_d  = 1'b0;
    unique case (state_q)
      S_IDLE:    if (xfer && bus.in_data == SYNC_BYTE) state_d = S_ADDR_LO;
      S_ADDR_LO: if (xfer) state_d = S_ADDR_HI;
      S_ADDR_HI: if (xfer) state_d = S_LEN_LO;
      S_LEN_LO:  if (xfer) state_d = S_LEN_HI;
      S_LEN_HI:  if (xfer) state_d = (hi_word == 16'd0) ? S_POST : S_DATA_LO;
      S_DATA_LO: if (xfer) state_d = S_DATA_HI;
      S_DATA_HI: if (xfer) state_d = (remaining_q == 16'd1) ? S_POST : S_DATA_LO;
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CSUM: begin
        if (xfer) begin
          state_d = S_DONE;
          fail_d  = (bus.in_data != csum_q);
        end
      end
`endif
      S_DONE:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
    if (timeout_hit) begin
      state_d = S_DONE;
      fail_d  = 1'b1;
    end
  end

  // State, datapath and output registers; synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      fail_q      <= 1'b0;
      byte_lo_q   <= '0;
      addr_q      <= '0;
      remaining_q <= '0;
      tcount_q    <= '0;
      in_ready_q  <= 1'b0;
      we_q        <= 1'b0;
      waddr_q     <= '0;
      wdata_q     <= '0;
      hold_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      words_q     <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q      <= '0;
`endif
    end else begin
      // NOTE: non-blocking assignments here so every register samples the
      // pre-edge values, regardless of statement order.
      state_q    <= state_d;
      in_ready_q <= (state_d != S_DONE);
      we_q       <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;

      // Frame outcome is latched on entry to DONE and held through it.
      if (state_q != S_DONE) fail_q <= fail_d;

      if (xfer || state_q == S_IDLE || state_q == S_DONE)
        tcount_q <= '0;
      else if (tcount_q != T_LAST)
        tcount_q <= tcount_q + TW'(1);

      if (xfer) begin
        unique case (state_q)
          S_IDLE: begin
            if (bus.in_data == SYNC_BYTE) begin
              hold_q  <= 1'b1;
              words_q <= '0;
            end
          end
          S_ADDR_LO, S_LEN_LO, S_DATA_LO: byte_lo_q <= bus.in_data;
          S_ADDR_HI: addr_q      <= hi_word[ADDR_WIDTH-1:0];
          S_LEN_HI:  remaining_q <= hi_word;
          S_DATA_HI: begin
            we_q        <= 1'b1;
            wdata_q     <= hi_word;
            waddr_q     <= addr_q;
            addr_q      <= addr_q + ADDR_WIDTH'(1);
            words_q     <= words_q + 16'd1;
            remaining_q <= remaining_q - 16'd1;
          end
          default: ;
        endcase
      end

`ifdef IMEM_LOADER_CHECKSUM_EN
      if (xfer && state_q == S_IDLE)
        csum_q <= '0;
      else if (xfer && state_q != S_CSUM && state_q != S_DONE)
        csum_q <= csum_q + bus.in_data;
`endif

      if (state_q == S_DONE) begin
        hold_q <= 1'b0;
        done_q <= !fail_q;
        err_q  <= fail_q;
      end
    end
  end

  assign bus.in_ready     = in_ready_q;
  assign bus.altair_we    = we_q;
  assign bus.altair_waddr = waddr_q;
  assign bus.altair_wdata = wdata_q;
  assign bus.cpu_hold     = hold_q;
  assign bus.load_done    = done_q;
  assign bus.load_err     = err_q;
  assign bus.words_loaded = words_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed testbench for imem_loader (ADDR_WIDTH=14, TIMEOUT_CYCLES=16).
// Builds with or without IMEM_LOADER_CHECKSUM_EN; expected values follow the macro.
module tb_imem_loader;
  localparam int AW = 14;
  localparam int TO = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  imem_loader_if #(.ADDR_WIDTH(AW)) bus ();

  imem_loader #(
    .ADDR_WIDTH    (AW),
    .SYNC_BYTE     (8'hA5),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef logic [7:0] bytes_t[$];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Monitor: log writes and status pulses mid-cycle.
  logic [15:0] wr_addr[$];
  logic [15:0] wr_data[$];
  int   done_cnt = 0, err_cnt = 0, hold_cycles = 0;
  logic prev_hold = 1'b0, done_hold = 1'b1, done_prev_hold = 1'b0;

  always @(negedge clk) begin
    if (bus.altair_we) begin
      wr_addr.push_back(16'(bus.altair_waddr));
      wr_data.push_back(bus.altair_wdata);
    end
    if (bus.load_done) begin
      done_cnt++;
      done_hold      = bus.cpu_hold;
      done_prev_hold = prev_hold;
    end
    if (bus.load_err) err_cnt++;
    if (bus.cpu_hold) hold_cycles++;
    prev_hold = bus.cpu_hold;
  end

  int b_we, b_done, b_err, b_hold;
  task automatic snap();
    b_we   = wr_addr.size();
    b_done = done_cnt;
    b_err  = err_cnt;
    b_hold = hold_cycles;
  endtask

  function automatic logic [7:0] csum_of(input bytes_t f);
    logic [7:0] s = 8'h00;
    for (int i = 1; i < f.size(); i++) s = s + f[i];
    return s;
  endfunction

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Present one byte; returns the number of cycles it was held off.
  task automatic send_byte(input logic [7:0] b, output int stalls);
    logic acc;
    acc          = 1'b0;
    stalls       = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    for (int i = 0; i < 8; i++) begin
      acc = bus.in_ready;
      @(posedge clk);
      #1;
      if (acc) break;
      stalls++;
    end
    bus.in_valid = 1'b0;
    if (!acc) check("accept_bound", 32'(acc), 32'd1);
  endtask

  task automatic send_frame(input bytes_t f);
    int s;
    for (int i = 0; i < f.size(); i++) send_byte(f[i], s);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bytes_t f;
    int     s;
    int     n;

    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;

    // Reset state.
    rst_n = 1'b0;
    idle(3);
    check("reset_ctl", {bus.in_ready, bus.altair_we, bus.cpu_hold, bus.load_done, bus.load_err}, 0);
    check("reset_words", bus.words_loaded, 0);
    check("reset_wbus", {bus.altair_waddr, bus.altair_wdata}, 0);
    rst_n = 1'b1;
    idle(1);
    check("ready_after_reset", bus.in_ready, 1);

    // Test 1: two words at 0x100; load_done and cpu_hold fall together.
    snap();
    f = '{8'hA5, 8'h00, 8'h01, 8'h02, 8'h00, 8'h34, 8'h12, 8'h78, 8'h56};
`ifdef IMEM_LOADER_CHECKSUM_EN
    f.push_back(csum_of(f));  // 0x17
`endif
    for (int i = 0; i < f.size(); i++) begin
      send_byte(f[i], s);
      if (i == 6) begin
        // One clock after the DATA_HI byte the write is on the port.
        check("t1_we_latency", bus.altair_we, 1);
        check("t1_first_word", {2'b00, bus.altair_waddr, bus.altair_wdata}, {16'h0100, 16'h1234});
      end
    end
    idle(3);
    check("t1_nwrites", wr_addr.size() - b_we, 2);
    check("t1_w0", {wr_addr[b_we],   wr_data[b_we]},   {16'h0100, 16'h1234});
    check("t1_w1", {wr_addr[b_we+1], wr_data[b_we+1]}, {16'h0101, 16'h5678});
    check("t1_done", done_cnt - b_done, 1);
    check("t1_err", err_cnt - b_err, 0);
    check("t1_words", bus.words_loaded, 2);
    check("t1_hold_with_done", {done_prev_hold, done_hold}, 2'b10);

    // Test 2: address 0xFFFF truncates to 0x3FFF and wraps; a SYNC-valued data byte is data.
    snap();
    f = '{8'hA5, 8'hFF, 8'hFF, 8'h02, 8'h00, 8'hA5, 8'h11, 8'h22, 8'h22};
`ifdef IMEM_LOADER_CHECKSUM_EN
    f.push_back(csum_of(f));
`endif
    send_frame(f);
    idle(3);
    check("t2_nwrites", wr_addr.size() - b_we, 2);
    check("t2_w0", {wr_addr[b_we],   wr_data[b_we]},   {16'h3FFF, 16'h11A5});
    check("t2_w1", {wr_addr[b_we+1], wr_data[b_we+1]}, {16'h0000, 16'h2222});
    check("t2_done", done_cnt - b_done, 1);

    // Test 3: LEN=0, no writes; hold spans SYNC..LEN_HI (+CSUM) plus DONE.
    snap();
    f = '{8'hA5, 8'h00, 8'h02, 8'h00, 8'h00};
`ifdef IMEM_LOADER_CHECKSUM_EN
    f.push_back(csum_of(f));  // 0x02
`endif
    send_frame(f);
    idle(3);
    check("t3_nwrites", wr_addr.size() - b_we, 0);
    check("t3_done", done_cnt - b_done, 1);
    check("t3_words", bus.words_loaded, 0);
`ifdef IMEM_LOADER_CHECKSUM_EN
    check("t3_hold_clks", hold_cycles - b_hold, 6);
`else
    check("t3_hold_clks", hold_cycles - b_hold, 5);
`endif

    // Test 4: stall after ADDR_HI. 16 idle clocks, one DONE clock, then load_err.
    snap();
    f = '{8'hA5, 8'h00, 8'h01};
    send_frame(f);
    n = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (bus.load_err) begin
        n = i;
        break;
      end
    end
    check("t4_err_latency", n, 17);
    check("t4_hold", bus.cpu_hold, 0);
    check("t4_nwrites", wr_addr.size() - b_we, 0);
    check("t4_done", done_cnt - b_done, 0);
    idle(1);
    check("t4_err_pulse", err_cnt - b_err, 1);
    snap();
    f = '{8'hA5, 8'h00, 8'h02, 8'h00, 8'h00};
`ifdef IMEM_LOADER_CHECKSUM_EN
    f.push_back(csum_of(f));
`endif
    send_frame(f);
    idle(3);
    check("t4_new_frame_done", done_cnt - b_done, 1);

    // Test 5: reset the cycle after DATA_LO; nothing written, byte 0x34 ignored in IDLE.
    snap();
    f = '{8'hA5, 8'h00, 8'h01, 8'h01, 8'h00, 8'h34};
    send_frame(f);
    rst_n = 1'b0;
    idle(1);
    check("t5_reset_ctl", {bus.in_ready, bus.altair_we, bus.cpu_hold, bus.load_done, bus.load_err}, 0);
    check("t5_reset_words", bus.words_loaded, 0);
    idle(1);
    rst_n = 1'b1;
    idle(1);
    send_byte(8'h34, s);
    idle(3);
    check("t5_nwrites", wr_addr.size() - b_we, 0);
    check("t5_pulses", (done_cnt - b_done) + (err_cnt - b_err), 0);
    check("t5_hold", bus.cpu_hold, 0);

    // Test 6: frame from test 1 (bad CSUM when enabled), then a byte arriving during DONE.
    snap();
    f = '{8'hA5, 8'h00, 8'h01, 8'h02, 8'h00, 8'h34, 8'h12, 8'h78, 8'h56};
`ifdef IMEM_LOADER_CHECKSUM_EN
    f.push_back(csum_of(f) + 8'h01);  // 0x18, one off
`endif
    send_frame(f);
    send_byte(8'hC1, s);
    check("t6_done_stall", s, 1);
    idle(3);
    check("t6_nwrites", wr_addr.size() - b_we, 2);
    check("t6_w1", {wr_addr[b_we+1], wr_data[b_we+1]}, {16'h0101, 16'h5678});
`ifdef IMEM_LOADER_CHECKSUM_EN
    check("t6_err", err_cnt - b_err, 1);
    check("t6_done", done_cnt - b_done, 0);
`else
    check("t6_err", err_cnt - b_err, 0);
    check("t6_done", done_cnt - b_done, 1);
`endif
    check("t6_hold", bus.cpu_hold, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
